// File: rtl/spi_sram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_sram_responder_pkg
// Purpose : Command codes and responder state encoding shared with the initiator.
// Revision: 1.0 - initial release
// ============================================================================
package spi_sram_responder_pkg;

   localparam logic [7:0] READ_CMD  = 8'h03;
   localparam logic [7:0] WRITE_CMD = 8'h02;

   typedef enum logic [2:0] {
      CMD    = 3'd0,
      ADDR   = 3'd1,
      WDATA  = 3'd2,
      RDATA  = 3'd3,
      IGNORE = 3'd4
   } spi_resp_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_sram_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : spi_sram_responder_if
// Purpose : SPI pins, backdoor read port and write-commit strobe of the responder.
// Revision: 1.0 - initial release
// ============================================================================
interface spi_sram_responder_if #(
   parameter int ADDR_W = 8
);
   logic              sclk;
   logic              cs;
   logic              mosi;
   logic              miso;
   logic [ADDR_W-1:0] dbg_addr;
   logic [7:0]        dbg_data;
   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              busy;

   modport slave (
      input  sclk, cs, mosi, dbg_addr,
      output miso, dbg_data, wr_valid, wr_addr, wr_data, busy
   );

   modport master (
      output sclk, cs, mosi, dbg_addr,
      input  miso, dbg_data, wr_valid, wr_addr, wr_data, busy
   );
endinterface
`default_nettype wire

// File: rtl/spi_sram_responder_array.sv
`default_nettype none
// ============================================================================
// Module  : spi_sram_responder_array
// Purpose : DEPTH x 8 byte storage, one write port, two asynchronous read ports.
// Revision: 1.0 - initial release
// ============================================================================
module spi_sram_responder_array #(
   parameter int         ADDR_W   = 8,
   parameter logic [7:0] MEM_INIT = 8'h00
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              we_i,
   input  wire logic [ADDR_W-1:0] waddr_i,
   input  wire logic [7:0]        wdata_i,
   input  wire logic [ADDR_W-1:0] raddr_a_i,
   output      logic [7:0]        rdata_a_o,
   input  wire logic [ADDR_W-1:0] raddr_b_i,
   output      logic [7:0]        rdata_b_o
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [7:0] mem_q [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= MEM_INIT;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = mem_q[raddr_a_i];
   assign rdata_b_o = mem_q[raddr_b_i];

endmodule
`default_nettype wire

// File: rtl/spi_sram_responder.sv
`default_nettype none
// ============================================================================
// Module  : spi_sram_responder
// Purpose : Mode-0 SPI target emulating a 23LC-style serial SRAM (sequential mode).
// Revision: 1.0 - initial release
// ============================================================================
module spi_sram_responder
   import spi_sram_responder_pkg::*;
#(
   parameter int         ADDR_W   = 8,
   parameter logic [7:0] MEM_INIT = 8'h00
) (
   input wire logic            clk,
   input wire logic            rst,
   spi_sram_responder_if.slave bus
);
   // Shifter keeps just enough history for the 8-bit command and the used address bits.
   localparam int SH_W = (ADDR_W > 8) ? ADDR_W : 8;

   spi_resp_state_t   state_q;
   logic              sclk_q;
   logic [3:0]        cnt_q;
   logic [SH_W-2:0]   shift_q;
   logic              write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        tx_q;
   logic              wr_valid_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [7:0]        wr_data_q;

   logic              rise;
   logic              fall;
   logic [SH_W-1:0]   shift_d;
   logic              we;
   logic [ADDR_W-1:0] rd_idx;
   logic [7:0]        rd_data;

   assign rise    = ~bus.cs &  bus.sclk & ~sclk_q;
   assign fall    = ~bus.cs & ~bus.sclk &  sclk_q;
   assign shift_d = {shift_q, bus.mosi};
   assign we      = rise && (state_q == WDATA) && (cnt_q == 4'd7);

   // The first read byte is fetched with the address still being shifted in.
   assign rd_idx  = (state_q == ADDR) ? shift_d[ADDR_W-1:0] : addr_q;

   spi_sram_responder_array #(
      .ADDR_W   (ADDR_W),
      .MEM_INIT (MEM_INIT)
   ) u_array (
      .clk       (clk),
      .rst       (rst),
      .we_i      (we),
      .waddr_i   (addr_q),
      .wdata_i   (shift_d[7:0]),
      .raddr_a_i (rd_idx),
      .rdata_a_o (rd_data),
      .raddr_b_i (bus.dbg_addr),
      .rdata_b_o (bus.dbg_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= CMD;
         sclk_q     <= 1'b0;
         cnt_q      <= 4'd0;
         shift_q    <= '0;
         write_q    <= 1'b0;
         addr_q     <= '0;
         tx_q       <= 8'h00;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= 8'h00;
      end else begin
         sclk_q     <= bus.sclk;
         wr_valid_q <= 1'b0;
         if (we) begin
            wr_valid_q <= 1'b1;
            wr_addr_q  <= addr_q;
            wr_data_q  <= shift_d[7:0];
         end
         if (bus.cs) begin
            state_q <= CMD;
            cnt_q   <= 4'd0;
            shift_q <= '0;
            tx_q    <= 8'h00;
         end else if (rise) begin
            shift_q <= shift_d[SH_W-2:0];
            cnt_q   <= cnt_q + 4'd1;
            case (state_q)
               CMD: begin
                  if (cnt_q == 4'd7) begin
                     cnt_q <= 4'd0;
                     if (shift_d[7:0] == WRITE_CMD) begin
                        state_q <= ADDR;
                        write_q <= 1'b1;
                     end else if (shift_d[7:0] == READ_CMD) begin
                        state_q <= ADDR;
                        write_q <= 1'b0;
                     end else begin
                        state_q <= IGNORE;
                     end
                  end
               end
               ADDR: begin
                  if (cnt_q == 4'd15) begin
                     cnt_q  <= 4'd0;
                     addr_q <= shift_d[ADDR_W-1:0];
                     if (write_q) begin
                        state_q <= WDATA;
                     end else begin
                        state_q <= RDATA;
                        tx_q    <= rd_data;
                     end
                  end
               end
               WDATA, RDATA: begin
                  if (cnt_q == 4'd7) begin
                     cnt_q  <= 4'd0;
                     addr_q <= addr_q + ADDR_W'(1);
                  end
               end
               IGNORE: begin
                  cnt_q <= 4'd0;
               end
               default: begin
                  state_q <= CMD;
                  cnt_q   <= 4'd0;
               end
            endcase
         end else if (fall && (state_q == RDATA)) begin
            // A fall at a byte boundary loads the next byte instead of shifting.
            tx_q <= (cnt_q == 4'd0) ? rd_data : {tx_q[6:0], 1'b0};
         end
      end
   end

   assign bus.miso     = tx_q[7];
   assign bus.wr_valid = wr_valid_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.busy     = ~bus.cs & ((state_q != CMD) | (cnt_q != 4'd0));

endmodule
`default_nettype wire

// File: tb/tb_spi_sram_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_sram_responder
// Purpose : Self-checking bench for spi_sram_responder (table + corner sequences).
// Revision: 1.0 - initial release
// ============================================================================
module tb_spi_sram_responder;
   import spi_sram_responder_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_sram_responder_if #(.ADDR_W(8)) bus ();

   spi_sram_responder #(
      .ADDR_W   (8),
      .MEM_INIT (8'h00)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        is_wr;
      logic [15:0] addr;
      logic [7:0]  data;
   } vec_t;

   int          total = 0;
   int          bad   = 0;
   logic [7:0]  model [256];
   logic [15:0] wr_q [$];
   logic [7:0]  rd_q [$];
   logic [15:0] wr_e;
   vec_t        vecs [9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && bus.wr_valid === 1'b1) begin
         if (wr_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL wr_valid_unexpected: got addr=%0h data=%0h expected no commit",
                     bus.wr_addr, bus.wr_data);
         end else begin
            wr_e = wr_q.pop_front();
            chk("wr_addr", {24'h0, bus.wr_addr}, {24'h0, wr_e[15:8]});
            chk("wr_data", {24'h0, bus.wr_data}, {24'h0, wr_e[7:0]});
         end
      end
   end

   task automatic bit_x(input logic b, output logic m);
      @(negedge clk);
      bus.mosi = b;
      bus.sclk = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus.sclk = 1'b1;
      @(negedge clk);
      @(negedge clk);
      m        = bus.miso;
      bus.sclk = 1'b0;
   endtask

   task automatic byte_x(input logic [7:0] t, output logic [7:0] r);
      logic m;
      for (int i = 7; i >= 0; i--) begin
         bit_x(t[i], m);
         r[i] = m;
      end
   endtask

   task automatic cs_begin();
      @(negedge clk);
      bus.sclk = 1'b0;
      bus.cs   = 1'b0;
      @(negedge clk);
   endtask

   task automatic cs_end();
      @(negedge clk);
      bus.cs = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic header(input logic [7:0] cmd, input logic [15:0] a);
      logic [7:0] r;
      byte_x(cmd, r);
      byte_x(a[15:8], r);
      byte_x(a[7:0], r);
   endtask

   task automatic dbg_chk(input string nm, input logic [7:0] a, input logic [7:0] exp);
      bus.dbg_addr = a;
      #1;
      chk(nm, {24'h0, bus.dbg_data}, {24'h0, exp});
   endtask

   task automatic run_vec(input vec_t v);
      logic [7:0] r;
      cs_begin();
      header(v.is_wr ? WRITE_CMD : READ_CMD, v.addr);
      if (v.is_wr) begin
         wr_q.push_back({v.addr[7:0], v.data});
         model[v.addr[7:0]] = v.data;
         byte_x(v.data, r);
      end else begin
         rd_q.push_back(v.data);
         byte_x(8'h00, r);
         chk("rd_byte", {24'h0, r}, {24'h0, rd_q.pop_front()});
      end
      cs_end();
      if (v.is_wr) dbg_chk("dbg_after_write", v.addr[7:0], v.data);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected test completion");
      $fatal(1);
   end

   initial begin
      logic [7:0] r;
      logic       m;
      logic [7:0] pat;

      vecs[0] = '{1'b1, 16'h0012, 8'hA5};
      vecs[1] = '{1'b0, 16'h0012, 8'hA5};
      vecs[2] = '{1'b1, 16'h0034, 8'h3C};
      vecs[3] = '{1'b1, 16'h0080, 8'h81};
      vecs[4] = '{1'b0, 16'h0034, 8'h3C};
      vecs[5] = '{1'b0, 16'h0080, 8'h81};
      vecs[6] = '{1'b1, 16'h1234, 8'h5A};
      vecs[7] = '{1'b0, 16'h0034, 8'h5A};
      vecs[8] = '{1'b0, 16'h0012, 8'hA5};

      bus.cs       = 1'b1;
      bus.sclk     = 1'b0;
      bus.mosi     = 1'b0;
      bus.dbg_addr = 8'h00;
      for (int i = 0; i < 256; i++) model[i] = 8'h00;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_miso", {31'h0, bus.miso}, 32'h0);
      chk("reset_busy", {31'h0, bus.busy}, 32'h0);
      chk("reset_wr_valid", {31'h0, bus.wr_valid}, 32'h0);
      for (int i = 0; i < 256; i++) dbg_chk("reset_dbg", 8'(i), 8'h00);

      for (int i = 0; i < 9; i++) run_vec(vecs[i]);

      // Bit-level read of 0x12: 1,0,1,0,0,1,0,1
      pat = 8'hA5;
      cs_begin();
      bit_x(1'b0, m);
      chk("busy_mid_cmd", {31'h0, bus.busy}, 32'h1);
      for (int i = 6; i >= 0; i--) bit_x(READ_CMD[i], m);
      byte_x(8'h00, r);
      byte_x(8'h12, r);
      for (int i = 7; i >= 0; i--) begin
         bit_x(1'b0, m);
         chk("rd_bit", {31'h0, m}, {31'h0, pat[i]});
      end
      cs_end();

      // Sequential write across the top of the array, then read it back.
      cs_begin();
      header(WRITE_CMD, 16'h00FF);
      wr_q.push_back({8'hFF, 8'h11});
      byte_x(8'h11, r);
      wr_q.push_back({8'h00, 8'h22});
      byte_x(8'h22, r);
      cs_end();
      model[8'hFF] = 8'h11;
      model[8'h00] = 8'h22;
      dbg_chk("wrap_dbg_ff", 8'hFF, 8'h11);
      dbg_chk("wrap_dbg_00", 8'h00, 8'h22);
      cs_begin();
      header(READ_CMD, 16'h00FF);
      rd_q.push_back(8'h11);
      rd_q.push_back(8'h22);
      byte_x(8'h00, r);
      chk("wrap_rd0", {24'h0, r}, {24'h0, rd_q.pop_front()});
      byte_x(8'h00, r);
      chk("wrap_rd1", {24'h0, r}, {24'h0, rd_q.pop_front()});
      cs_end();

      // Unknown command: consumed silently.
      cs_begin();
      byte_x(8'h05, r);
      chk("busy_ignore", {31'h0, bus.busy}, 32'h1);
      for (int i = 0; i < 24; i++) begin
         bit_x(1'b1, m);
         chk("ignore_miso", {31'h0, m}, 32'h0);
      end
      cs_end();
      chk("busy_cs_high", {31'h0, bus.busy}, 32'h0);
      run_vec('{1'b0, 16'h0034, 8'h5A});

      // Write aborted after 5 data bits.
      cs_begin();
      header(WRITE_CMD, 16'h0040);
      for (int i = 0; i < 5; i++) bit_x(1'b1, m);
      cs_end();
      dbg_chk("abort_dbg", 8'h40, model[8'h40]);
      run_vec('{1'b0, 16'h0040, 8'h00});

      // Reset in the middle of a read.
      cs_begin();
      header(READ_CMD, 16'h0012);
      chk("rd_loaded_miso", {31'h0, bus.miso}, {31'h0, model[8'h12][7]});
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_miso", {31'h0, bus.miso}, 32'h0);
      chk("rst_busy", {31'h0, bus.busy}, 32'h0);
      for (int i = 0; i < 256; i++) model[i] = 8'h00;
      dbg_chk("rst_dbg_12", 8'h12, 8'h00);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cs_end();
      run_vec('{1'b0, 16'h0012, 8'h00});

      repeat (4) @(negedge clk);
      chk("wr_q_drained", wr_q.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
